// File: rtl/bus_cdc_stall_ctrl.sv
// CPU-side stall controller in front of bus_cdc: converts busy into a halt for crossed reads,
// captures returned data and bounds each stall with a timeout watchdog.
module bus_cdc_stall_ctrl #(
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          TimeoutCycles = 1024,
    parameter int unsigned          ArmCycles     = 2,
    parameter logic [DataWidth-1:0] TimeoutData   = DataWidth'(32'hDEAD_BEEF),
    parameter int unsigned          ErrCountWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     read_access_i,
    input  logic                     busy_i,
    input  logic [DataWidth-1:0]     data_i,
    input  logic                     clear_count_i,
    output logic                     halt_o,
    output logic [DataWidth-1:0]     data_o,
    output logic                     data_valid_o,
    output logic                     timeout_o,
    output logic [ErrCountWidth-1:0] timeout_count_o
);

    // The counter is shared by ARM and STALL, so it must cover whichever window is longer.
    localparam int unsigned CntMax   = (TimeoutCycles > ArmCycles) ? TimeoutCycles : ArmCycles;
    localparam int unsigned CntWidth = $clog2(CntMax + 1);

    localparam logic [CntWidth-1:0] StallLast = CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] ArmLast   = CntWidth'(ArmCycles - 1);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StArm       = 3'd1;
    localparam logic [2:0] StStall     = 3'd2;
    localparam logic [2:0] StDrain     = 3'd3;
    localparam logic [2:0] StDrainHold = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d;
    logic [DataWidth-1:0]     data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     timeout_q, timeout_d;
    logic [ErrCountWidth-1:0] count_q, count_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (read_access_i) begin
                    state_d = StArm;
                    cnt_d   = '0;
                end
            end
            StArm: begin
                if (busy_i) begin
                    state_d = StStall;
                    cnt_d   = '0;
                end else if (cnt_q == ArmLast) begin
                    // busy never rose: treat the access as unmapped and complete it now
                    state_d = StIdle;
                    cnt_d   = '0;
                    data_d  = data_i;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStall: begin
                if (cnt_q == StallLast) begin
                    state_d   = StDrain;
                    cnt_d     = '0;
                    data_d    = TimeoutData;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                end else if (!busy_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    data_d  = data_i;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                // The abandoned transfer is still in flight; its data is dropped.
                if (!busy_i) begin
                    state_d = StIdle;
                end else if (read_access_i) begin
                    state_d = StDrainHold;
                end
            end
            StDrainHold: begin
                if (!busy_i) begin
                    state_d = StArm;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (timeout_d) begin
            if (clear_count_i) begin
                count_d = ErrCountWidth'(1);
            end else if (count_q != {ErrCountWidth{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
        end else if (clear_count_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    // The access cycle itself must stall: busy only rises on the following cycle.
    always_comb begin
        halt_o = (state_q == StArm) || (state_q == StStall) || (state_q == StDrainHold) ||
                 ((state_q == StIdle) && read_access_i);
    end

    assign data_o          = data_q;
    assign data_valid_o    = valid_q;
    assign timeout_o       = timeout_q;
    assign timeout_count_o = count_q;

endmodule

// File: tb/tb_bus_cdc_stall_ctrl.sv
// Directed self-checking bench for bus_cdc_stall_ctrl (TimeoutCycles=16, ArmCycles=2).
module tb_bus_cdc_stall_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_access = 1'b0;
    logic          busy = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          clear_count = 1'b0;
    logic          halt;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          timeout;
    logic [7:0]    tcount;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    bus_cdc_stall_ctrl #(
        .DataWidth    (DW),
        .TimeoutCycles(TO),
        .ArmCycles    (2),
        .TimeoutData  (32'hDEAD_BEEF),
        .ErrCountWidth(8)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .read_access_i  (read_access),
        .busy_i         (busy),
        .data_i         (data_in),
        .clear_count_i  (clear_count),
        .halt_o         (halt),
        .data_o         (data_out),
        .data_valid_o   (data_valid),
        .timeout_o      (timeout),
        .timeout_count_o(tcount)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns later, same cycle.
    task automatic drive(input logic ra, input logic b, input logic [DW-1:0] d,
                         input logic clr, input logic rst);
        @(negedge clk);
        read_access = ra;
        busy        = b;
        data_in     = d;
        clear_count = clr;
        reset       = rst;
        #1;
    endtask

    // Read that hits the watchdog; returns just before the edge that enters DRAIN.
    task automatic force_timeout(input logic clr_last);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        for (int s = 0; s < TO; s++) begin
            drive(1'b0, 1'b1, 32'h0000_AAAA, (s == TO - 1) ? clr_last : 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (halt !== 1'b0) $display("FAIL reset_halt: got %b want 0", halt); else passes++;
        checks++; if (data_out !== 32'h0) $display("FAIL reset_data: got %h want 0", data_out); else passes++;
        checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid); else passes++;
        checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else passes++;
        checks++; if (tcount !== 8'd0) $display("FAIL reset_count: got %0d want 0", tcount); else passes++;
    endtask

    task automatic test_normal_read();
        // c0 access, c1 ARM (busy rises), c2-5 STALL busy, c6 STALL busy low with data
        for (int c = 0; c < 7; c++) begin
            drive(c == 0, (c >= 1) && (c <= 5), (c == 6) ? 32'h0000_1234 : 32'h0000_5555,
                  1'b0, 1'b0);
            checks++; if (halt !== 1'b1) $display("FAIL normal_halt c%0d: got %b want 1", c, halt); else passes++;
            checks++; if (data_valid !== 1'b0) $display("FAIL normal_valid_early c%0d: got %b want 0", c, data_valid); else passes++;
        end
        drive(1'b0, 1'b0, 32'h0000_9999, 1'b0, 1'b0);
        checks++; if (halt !== 1'b0) $display("FAIL normal_release: got %b want 0", halt); else passes++;
        checks++; if (data_valid !== 1'b1) $display("FAIL normal_valid: got %b want 1", data_valid); else passes++;
        checks++; if (data_out !== 32'h0000_1234) $display("FAIL normal_data: got %h want 00001234", data_out); else passes++;
        checks++; if (timeout !== 1'b0) $display("FAIL normal_timeout: got %b want 0", timeout); else passes++;
        drive(1'b0, 1'b0, 32'h0000_9999, 1'b0, 1'b0);
        checks++; if (data_valid !== 1'b0) $display("FAIL normal_valid_pulse: got %b want 0", data_valid); else passes++;
        checks++; if (data_out !== 32'h0000_1234) $display("FAIL normal_data_hold: got %h want 00001234", data_out); else passes++;
    endtask

    task automatic test_unmapped();
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 1'b0, 32'h0000_7777, 1'b0, 1'b0);
            checks++; if (halt !== 1'b1) $display("FAIL unmapped_halt c%0d: got %b want 1", c, halt); else passes++;
        end
        drive(1'b0, 1'b0, 32'h0000_8888, 1'b0, 1'b0);
        checks++; if (halt !== 1'b0) $display("FAIL unmapped_release: got %b want 0", halt); else passes++;
        checks++; if (data_valid !== 1'b1) $display("FAIL unmapped_valid: got %b want 1", data_valid); else passes++;
        checks++; if (data_out !== 32'h0000_7777) $display("FAIL unmapped_data: got %h want 00007777", data_out); else passes++;
        checks++; if (timeout !== 1'b0) $display("FAIL unmapped_timeout: got %b want 0", timeout); else passes++;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 1'b0, 32'h0000_0011, 1'b0, 1'b0);
        end
        // completion cycle of the first read also carries the next access
        drive(1'b1, 1'b0, 32'h0000_0022, 1'b0, 1'b0);
        checks++; if (data_valid !== 1'b1) $display("FAIL b2b_valid_a: got %b want 1", data_valid); else passes++;
        checks++; if (data_out !== 32'h0000_0011) $display("FAIL b2b_data_a: got %h want 00000011", data_out); else passes++;
        checks++; if (halt !== 1'b1) $display("FAIL b2b_halt_access: got %b want 1", halt); else passes++;
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0, 32'h0000_0022, 1'b0, 1'b0);
            checks++; if (halt !== 1'b1) $display("FAIL b2b_halt_arm c%0d: got %b want 1", c, halt); else passes++;
        end
        drive(1'b0, 1'b0, 32'h0000_0033, 1'b0, 1'b0);
        checks++; if (halt !== 1'b0) $display("FAIL b2b_release: got %b want 0", halt); else passes++;
        checks++; if (data_out !== 32'h0000_0022) $display("FAIL b2b_data_b: got %h want 00000022", data_out); else passes++;
    endtask

    task automatic test_timeout();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        for (int s = 0; s < TO; s++) begin
            drive(1'b0, 1'b1, 32'h0000_AAAA, 1'b0, 1'b0);
            checks++; if (halt !== 1'b1) $display("FAIL to_halt s%0d: got %b want 1", s, halt); else passes++;
            checks++; if (timeout !== 1'b0) $display("FAIL to_early s%0d: got %b want 0", s, timeout); else passes++;
        end
        drive(1'b0, 1'b1, 32'h0000_AAAA, 1'b0, 1'b0);
        checks++; if (halt !== 1'b0) $display("FAIL to_release: got %b want 0", halt); else passes++;
        checks++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout); else passes++;
        checks++; if (data_valid !== 1'b1) $display("FAIL to_valid: got %b want 1", data_valid); else passes++;
        checks++; if (data_out !== 32'hDEAD_BEEF) $display("FAIL to_data: got %h want deadbeef", data_out); else passes++;
        checks++; if (tcount !== 8'd1) $display("FAIL to_count: got %0d want 1", tcount); else passes++;
        drive(1'b0, 1'b0, 32'h0000_AAAA, 1'b0, 1'b0);
        checks++; if (timeout !== 1'b0) $display("FAIL to_pulse_end: got %b want 0", timeout); else passes++;
        checks++; if (halt !== 1'b0) $display("FAIL to_drain_halt: got %b want 0", halt); else passes++;
        drive(1'b0, 1'b0, 32'h0000_AAAA, 1'b0, 1'b0);
        checks++; if (data_out !== 32'hDEAD_BEEF) $display("FAIL to_late_data: got %h want deadbeef", data_out); else passes++;
        checks++; if (data_valid !== 1'b0) $display("FAIL to_late_valid: got %b want 0", data_valid); else passes++;
    endtask

    task automatic test_drain_hold();
        force_timeout(1'b0);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        checks++; if (tcount !== 8'd2) $display("FAIL dh_count: got %0d want 2", tcount); else passes++;
        drive(1'b1, 1'b1, 32'h0000_BBBB, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 32'h0000_BBBB, 1'b0, 1'b0);
            checks++; if (halt !== 1'b1) $display("FAIL dh_hold_halt k%0d: got %b want 1", k, halt); else passes++;
            checks++; if (data_valid !== 1'b0) $display("FAIL dh_hold_valid k%0d: got %b want 0", k, data_valid); else passes++;
        end
        drive(1'b0, 1'b0, 32'h0000_BBBB, 1'b0, 1'b0);
        checks++; if (halt !== 1'b1) $display("FAIL dh_rearm_halt: got %b want 1", halt); else passes++;
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        checks++; if (halt !== 1'b1) $display("FAIL dh_arm_halt: got %b want 1", halt); else passes++;
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0000_4321, 1'b0, 1'b0);
        checks++; if (halt !== 1'b1) $display("FAIL dh_stall_halt: got %b want 1", halt); else passes++;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (halt !== 1'b0) $display("FAIL dh_release: got %b want 0", halt); else passes++;
        checks++; if (data_valid !== 1'b1) $display("FAIL dh_valid: got %b want 1", data_valid); else passes++;
        checks++; if (data_out !== 32'h0000_4321) $display("FAIL dh_data: got %h want 00004321", data_out); else passes++;
        checks++; if (tcount !== 8'd2) $display("FAIL dh_count_end: got %0d want 2", tcount); else passes++;
    endtask

    task automatic test_saturation();
        for (int i = 3; i <= 300; i++) begin
            force_timeout(1'b0);
            drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
            if (i == 254) begin
                checks++; if (tcount !== 8'd254) $display("FAIL sat_254: got %0d want 254", tcount); else passes++;
            end
        end
        checks++; if (tcount !== 8'd255) $display("FAIL sat_255: got %0d want 255", tcount); else passes++;
        // clear arriving with a timeout leaves exactly one recorded
        force_timeout(1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (timeout !== 1'b1) $display("FAIL clr_coinc_pulse: got %b want 1", timeout); else passes++;
        checks++; if (tcount !== 8'd1) $display("FAIL clr_coinc_count: got %0d want 1", tcount); else passes++;
        force_timeout(1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (tcount !== 8'd2) $display("FAIL clr_after_count: got %0d want 2", tcount); else passes++;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (tcount !== 8'd0) $display("FAIL clr_count: got %0d want 0", tcount); else passes++;
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (halt !== 1'b0) $display("FAIL rst_mid_halt: got %b want 0", halt); else passes++;
        checks++; if (data_out !== 32'h0) $display("FAIL rst_mid_data: got %h want 0", data_out); else passes++;
        checks++; if (data_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", data_valid); else passes++;
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (halt !== 1'b1) $display("FAIL rst_after_access: got %b want 1", halt); else passes++;
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0000_2468, 1'b0, 1'b0);
        checks++; if (halt !== 1'b1) $display("FAIL rst_after_stall: got %b want 1", halt); else passes++;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (halt !== 1'b0) $display("FAIL rst_after_release: got %b want 0", halt); else passes++;
        checks++; if (data_valid !== 1'b1) $display("FAIL rst_after_valid: got %b want 1", data_valid); else passes++;
        checks++; if (data_out !== 32'h0000_2468) $display("FAIL rst_after_data: got %h want 00002468", data_out); else passes++;
    endtask

    initial begin
        test_reset();
        test_normal_read();
        test_unmapped();
        test_back_to_back();
        test_timeout();
        test_drain_hold();
        test_saturation();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
